// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and the UART programmer, with a RUN/PROG mode FSM.
// Optional build macro DMEM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed UPG priority with CPU starvation guard.
module dmem_arbiter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpu_req_i,
  input  logic        cpu_wen_i,
  input  logic [13:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic        cpu_gnt_o,
  output logic        cpu_stall_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_dat_o,
  input  logic        upg_req_i,
  input  logic [13:0] upg_adr_i,
  input  logic [31:0] upg_dat_i,
  input  logic        upg_done_i,
  output logic        upg_gnt_o,
  output logic        ram_wen_o,
  output logic [13:0] ram_adr_o,
  output logic [31:0] ram_dat_o,
  input  logic [31:0] ram_dat_i,
  output logic        prog_mode_o
);

  // state | meaning
  // RUN   | normal operation, CPU and UPG arbitrated
  // PROG  | programming, only UPG writes granted
  typedef enum logic {RUN = 1'b0, PROG = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        cpu_gnt, upg_gnt;
  logic        cpu_tie_win;
  logic        rvalid_q;
  logic [31:0] dat_hold_q;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_cpu_q;

  assign cpu_tie_win = ~last_cpu_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     last_cpu_q <= 1'b1;
    else if (cpu_gnt) last_cpu_q <= 1'b1;
    else if (upg_gnt) last_cpu_q <= 1'b0;
  end
`else
  logic [2:0] starve_cnt_q;

  assign cpu_tie_win = (starve_cnt_q == 3'd4);

  // Only counts RUN-mode losses; PROG lockout is intentional and held, not counted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      starve_cnt_q <= 3'd0;
    else if (!cpu_req_i || cpu_gnt)
      starve_cnt_q <= 3'd0;
    else if (state_q == RUN && starve_cnt_q != 3'd4)
      starve_cnt_q <= starve_cnt_q + 3'd1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    upg_gnt = 1'b0;
    case (state_q)
      RUN: begin
        if (upg_req_i && !upg_done_i) state_d = PROG;
        if (cpu_req_i && upg_req_i) begin
          cpu_gnt = cpu_tie_win;
          upg_gnt = ~cpu_tie_win;
        end else begin
          cpu_gnt = cpu_req_i;
          upg_gnt = upg_req_i;
        end
      end
      PROG: begin
        upg_gnt = upg_req_i;
        if (upg_done_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!rst_n_i) begin
      cpu_gnt = 1'b0;
      upg_gnt = 1'b0;
    end
  end

  assign cpu_gnt_o   = cpu_gnt;
  assign upg_gnt_o   = upg_gnt;
  assign cpu_stall_o = cpu_req_i & ~cpu_gnt;
  assign prog_mode_o = (state_q == PROG);

  assign ram_wen_o = upg_gnt | (cpu_gnt & cpu_wen_i);
  assign ram_adr_o = upg_gnt ? upg_adr_i : (cpu_gnt ? cpu_adr_i : 14'd0);
  assign ram_dat_o = upg_gnt ? upg_dat_i : (cpu_gnt ? cpu_dat_i : 32'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rvalid_q   <= 1'b0;
      dat_hold_q <= 32'd0;
    end else begin
      rvalid_q <= cpu_gnt & ~cpu_wen_i;
      if (rvalid_q) dat_hold_q <= ram_dat_i;
    end
  end

  assign cpu_rvalid_o = rvalid_q;
  assign cpu_dat_o    = rvalid_q ? ram_dat_i : dat_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        cpu_req_i, cpu_wen_i;
  logic [13:0] cpu_adr_i;
  logic [31:0] cpu_dat_i;
  logic        cpu_gnt_o, cpu_stall_o, cpu_rvalid_o;
  logic [31:0] cpu_dat_o;
  logic        upg_req_i;
  logic [13:0] upg_adr_i;
  logic [31:0] upg_dat_i;
  logic        upg_done_i, upg_gnt_o;
  logic        ram_wen_o;
  logic [13:0] ram_adr_o;
  logic [31:0] ram_dat_o;
  logic [31:0] ram_dat_i;
  logic        prog_mode_o;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .cpu_req_i(cpu_req_i), .cpu_wen_i(cpu_wen_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_dat_o(cpu_dat_o),
    .upg_req_i(upg_req_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i),
    .upg_gnt_o(upg_gnt_o),
    .ram_wen_o(ram_wen_o), .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i),
    .prog_mode_o(prog_mode_o)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = i;
    if (i == 16) return 32'hDEADBEEF;
    return (v * 32'h9E3779B9) ^ 32'h1234_5678;
  endfunction

  // RAM environment: synchronous read, data one cycle after address
  logic [31:0] tb_mem [16384];
  bit          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 16384; i++) tb_mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (ram_wen_o) begin
      tb_mem[ram_adr_o] <= ram_dat_o;
    end
    ram_dat_i <= tb_mem[ram_adr_o];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] ref_mem [16384];
  bit          m_prog;
  int          m_starve;
  bit          m_last_cpu;
  bit          m_rd_pend;
  logic [31:0] m_rd_data;
  logic [31:0] m_hold;

  logic        obs_cgnt, obs_ugnt, obs_stall, obs_prog, obs_rvalid;
  logic [31:0] obs_dato;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_prog     = 1'b0;
    m_starve   = 0;
    m_last_cpu = 1'b1;
    m_rd_pend  = 1'b0;
    m_rd_data  = 32'd0;
    m_hold     = 32'd0;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [13:0] ca, input logic [31:0] cd,
                       input bit ur, input logic [13:0] ua, input logic [31:0] ud, input bit dn);
    cpu_req_i = cr; cpu_wen_i = cw; cpu_adr_i = ca; cpu_dat_i = cd;
    upg_req_i = ur; upg_adr_i = ua; upg_dat_i = ud; upg_done_i = dn;
  endtask

  // One cycle: inputs already driven at the falling edge; compare, then advance the model.
  task automatic step(input bit rst_after);
    bit          ec, eu;
    logic        ew;
    logic [13:0] ea;
    logic [31:0] ed;
    #2;
    if (!rst_n_i) model_reset();
    ec = 1'b0; eu = 1'b0;
    if (rst_n_i) begin
      if (m_prog) begin
        eu = upg_req_i;
      end else if (cpu_req_i && upg_req_i) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        ec = !m_last_cpu;
`else
        ec = (m_starve >= 4);
`endif
        eu = !ec;
      end else begin
        ec = cpu_req_i;
        eu = upg_req_i;
      end
    end
    if (eu)      begin ew = 1'b1;      ea = upg_adr_i; ed = upg_dat_i; end
    else if (ec) begin ew = cpu_wen_i; ea = cpu_adr_i; ed = cpu_dat_i; end
    else         begin ew = 1'b0;      ea = 14'd0;     ed = 32'd0;     end

    chk("cpu_gnt", cpu_gnt_o, ec);
    chk("upg_gnt", upg_gnt_o, eu);
    chk("cpu_stall", cpu_stall_o, cpu_req_i & ~ec);
    chk("ram_wen", ram_wen_o, ew);
    chk("ram_adr", ram_adr_o, ea);
    chk("ram_dat", ram_dat_o, ed);
    chk("cpu_rvalid", cpu_rvalid_o, m_rd_pend);
    chk("cpu_dat", cpu_dat_o, m_rd_pend ? m_rd_data : m_hold);
    chk("prog_mode", prog_mode_o, m_prog);

    obs_cgnt = cpu_gnt_o; obs_ugnt = upg_gnt_o; obs_stall = cpu_stall_o;
    obs_prog = prog_mode_o; obs_rvalid = cpu_rvalid_o; obs_dato = cpu_dat_o;

    if (rst_n_i) begin
      if (m_rd_pend) m_hold = m_rd_data;
      m_rd_pend = ec && !cpu_wen_i;
      if (m_rd_pend) m_rd_data = ref_mem[cpu_adr_i];
      if (ew) ref_mem[ea] = ed;
      if (!m_prog) m_starve = (cpu_req_i && !ec) ? ((m_starve < 4) ? m_starve + 1 : 4) : 0;
      else if (!cpu_req_i) m_starve = 0;
      if (ec) m_last_cpu = 1'b1;
      else if (eu) m_last_cpu = 1'b0;
      if (!m_prog && upg_req_i && !upg_done_i) m_prog = 1'b1;
      else if (m_prog && upg_done_i) m_prog = 1'b0;
    end
    if (rst_after) begin
      #1;
      rst_n_i = 1'b0;
      model_reset();
    end
    @(negedge clk);
  endtask

  initial begin
    int          upg_cnt;
    bit          stall_all;
    logic [9:0]  pat;
    logic [9:0]  pat_exp;

    for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst_n_i = 1'b0;
    drive(1, 0, 14'h10, 0, 1, 14'h5, 32'h55, 0);
    @(negedge clk);
    step(0);
    chk("reset_cpu_gnt", obs_cgnt, 0);
    chk("reset_upg_gnt", obs_ugnt, 0);
    step(0);
    rst_n_i = 1'b1;

    // single CPU read of a preloaded word
    drive(1, 0, 14'h0010, 32'd0, 0, 14'd0, 32'd0, 0);
    step(0);
    chk("r025_gnt", obs_cgnt, 1);
    drive(0, 0, 14'd0, 32'd0, 0, 14'd0, 32'd0, 0);
    step(0);
    chk("r025_rvalid", obs_rvalid, 1);
    chk("r025_dat", obs_dato, 32'hDEADBEEF);

    // programming burst with the CPU waiting
    upg_cnt = 0;
    stall_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 14'h0020, 32'd0, 1, 14'(i), $urandom, 0);
      step(0);
      upg_cnt += int'(obs_ugnt);
      stall_all &= obs_stall;
      chk("r026_prog", obs_prog, (i > 0));
    end
    chk("r026_upg_writes", upg_cnt, 4);
    chk("r026_stall", stall_all, 1);

    // leave programming; CPU gets in once back in RUN
    drive(1, 0, 14'h0002, 32'd0, 0, 14'd0, 32'd0, 1);
    step(0);
    chk("r027_prog_cpu_blocked", obs_cgnt, 0);
    drive(1, 0, 14'h0002, 32'd0, 0, 14'd0, 32'd0, 0);
    step(0);
    chk("r027_run", obs_prog, 0);
    chk("r027_cpu_gnt", obs_cgnt, 1);
    drive(0, 0, 14'd0, 32'd0, 0, 14'd0, 32'd0, 0);
    step(0);

    // continuous contention in RUN (done held high keeps it a patch write)
    rst_n_i = 1'b0;
    step(0);
    rst_n_i = 1'b1;
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 14'($urandom_range(0, 63)), 32'd0, 1, 14'($urandom_range(0, 63)), $urandom, 1);
      step(0);
      pat[k] = obs_cgnt;
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    pat_exp = 10'b10_1010_1010;
`else
    pat_exp = 10'b10_0001_0000;
`endif
    chk("r028_grant_pattern", pat, pat_exp);

    // reset lands while a read is in flight
    drive(1, 0, 14'h0010, 32'd0, 0, 14'd0, 32'd0, 0);
    step(1);
    chk("r030_gnt", obs_cgnt, 1);
    step(0);
    chk("r030_rvalid", obs_rvalid, 0);
    chk("r030_state_run", obs_prog, 0);
    rst_n_i = 1'b1;
    drive(0, 0, 14'd0, 32'd0, 0, 14'd0, 32'd0, 0);
    step(0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n_i = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 14'($urandom_range(0, 63)), $urandom,
            $urandom_range(0, 9) < 4, 14'($urandom_range(0, 63)), $urandom, $urandom_range(0, 9) < 3);
      step(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports: clk_i in 1, system clock; single clock domain, all state rising-edge.
REQ-002 SHALL have: rst_n_i in 1, asynchronous, active-low reset.
REQ-003 SHALL have CPU port: cpu_req_i in 1 access request; cpu_wen_i in 1 write(1)/read(0); cpu_adr_i in 14 word address; cpu_dat_i in 32 write data.
REQ-004 SHALL have CPU returns: cpu_gnt_o out 1 access issued this cycle; cpu_stall_o out 1 (cpu_req_i & ~cpu_gnt_o); cpu_rvalid_o out 1 read data valid; cpu_dat_o out 32 read data.
REQ-005 SHALL have UART-programmer port: upg_req_i in 1 write request; upg_adr_i in 14; upg_dat_i in 32; upg_done_i in 1 programming complete; upg_gnt_o out 1.
REQ-006 SHALL have RAM side: ram_wen_o out 1; ram_adr_o out 14; ram_dat_o out 32; ram_dat_i in 32, read data one cycle after address.
REQ-007 SHALL have prog_mode_o out 1, high while in PROG state.

Function
REQ-008 SHALL grant at most one requester per cycle; cpu_gnt_o & upg_gnt_o never both 1.
REQ-009 SHALL drive ram_wen_o/ram_adr_o/ram_dat_o combinationally from the granted requester; no grant -> ram_wen_o=0, ram_adr_o=0, ram_dat_o=0.
REQ-010 SHALL treat every UPG access as write (ram_wen_o=1 when upg_gnt_o).
REQ-011 SHALL implement states RUN, PROG; RUN->PROG when upg_req_i=1 and upg_done_i=0; PROG->RUN when upg_done_i=1; the upg_req_i in the transition cycle is arbitrated with RUN rules.
REQ-012 In PROG, SHALL grant upg_req_i every cycle it is high and never grant CPU.
REQ-013 In RUN, default (fixed priority): UPG wins ties; a lone requester is always granted same cycle.
REQ-014 SHALL keep 3-bit starve_cnt: increments each RUN cycle cpu_req_i=1 and not granted, clears on CPU grant or cpu_req_i=0; at starve_cnt=4 CPU wins the tie that cycle; saturates at 4.
REQ-015 SHALL register read-return: cpu_rvalid_o=1 exactly one cycle after a cycle with cpu_gnt_o=1 and cpu_wen_i=0, else 0.
REQ-016 SHALL drive cpu_dat_o = ram_dat_i when cpu_rvalid_o=1, else hold last returned value.
REQ-017 Back-to-back CPU reads SHALL produce back-to-back cpu_rvalid_o pulses, one per grant, in order.
REQ-018 A CPU read granted in the cycle RUN->PROG SHALL still return cpu_rvalid_o next cycle.
REQ-019 upg_done_i=1 with upg_req_i=1 in RUN SHALL be a normal arbitrated write (post-programming patch).

Reset
REQ-020 On rst_n_i=0, asynchronously: state=RUN, starve_cnt=0, cpu_rvalid_o=0, cpu_dat_o=0, prog_mode_o=0, priority pointer=CPU-last.
REQ-021 During reset, grants SHALL be 0 and ram_wen_o=0 regardless of requests.
REQ-022 Reset asserted mid-read SHALL suppress the pending cpu_rvalid_o.

Configuration
REQ-023 Macro DMEM_ARB_ROUND_ROBIN_EN defined: RUN ties go to the requester not granted most recently (1-bit pointer updated on each grant); starve_cnt removed/held 0.
REQ-024 Macro undefined: fixed UPG priority with starve_cnt per REQ-013/014; PROG behaviour identical in both builds.

Verification
REQ-025 Reset, then cpu_req_i=1, wen=0, adr=0x0010, RAM word 0xDEADBEEF -> cpu_gnt_o=1 same cycle; cpu_rvalid_o=1, cpu_dat_o=0xDEADBEEF next cycle.
REQ-026 upg_done_i=0, upg_req_i=1 adr=0x0000..0x0003 for 4 cycles with cpu_req_i=1 -> prog_mode_o=1, 4 UPG writes, cpu_stall_o=1 throughout.
REQ-027 In PROG, raise upg_done_i=1 -> next cycle RUN, pending CPU request granted.
REQ-028 RUN, both request continuously (fixed build) -> grant pattern UPG,UPG,UPG,UPG,CPU repeating.
REQ-029 Round-robin build, both request continuously -> grants alternate CPU/UPG each cycle.
REQ-030 Assert rst_n_i=0 the cycle after a CPU read grant -> cpu_rvalid_o stays 0, state RUN.
